// File: rtl/ctrl_pkg.sv
// +-----------------------------------------------------------------------------
// | ctrl_pkg : opcodes, ALU/shift encodings, FSM states, control-word layout
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  localparam logic [31:0] OP_LOADI = 32'h00;
  localparam logic [31:0] OP_MOV   = 32'h01;
  localparam logic [31:0] OP_ADD   = 32'h02;
  localparam logic [31:0] OP_SUB   = 32'h03;
  localparam logic [31:0] OP_AND   = 32'h04;
  localparam logic [31:0] OP_OR    = 32'h05;
  localparam logic [31:0] OP_J     = 32'h06;
  localparam logic [31:0] OP_BEQ   = 32'h07;
  localparam logic [31:0] OP_LWD   = 32'h08;
  localparam logic [31:0] OP_LWI   = 32'h09;
  localparam logic [31:0] OP_SWD   = 32'h0A;
  localparam logic [31:0] OP_SWI   = 32'h0B;
  localparam logic [31:0] OP_BNE   = 32'h0C;
  localparam logic [31:0] OP_SLL   = 32'h0D;
  localparam logic [31:0] OP_SRL   = 32'h0E;
  localparam logic [31:0] OP_SRA   = 32'h0F;
  localparam logic [31:0] OP_ROR   = 32'h10;
  localparam logic [31:0] OP_MULT  = 32'h11;

  localparam logic [2:0] ALU_FWD   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_MULT  = 3'b100;
  localparam logic [2:0] ALU_SHIFT = 3'b101;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_EXEC = 3'd1;
  localparam state_t S_MEM  = 3'd2;
  localparam state_t S_WB   = 3'd3;
  localparam state_t S_TRAP = 3'd4;

  typedef struct packed {
    logic       we;
    logic [2:0] aluop;
    logic       comp;
    logic       imm;
    logic       branch;
    logic       bne;
    logic       jump;
    logic [1:0] shift_mode;
    logic       read;
    logic       write;
  } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decoder.sv
// +-----------------------------------------------------------------------------
// | ctrl_decoder : combinational opcode -> {legal, is_mem, is_load, control word}
// | CTRL_OPCODE_EXT_EN adds bne/shift/mult opcodes. Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal,
  output logic                is_mem,
  output logic                is_load,
  output ctrl_word_t          cw
);

  logic [31:0] op_ext;
  assign op_ext = 32'(opcode);

  always_comb begin
    cw    = '0;
    legal = 1'b1;
    case (op_ext)
      OP_LOADI: begin cw.we = 1'b1; cw.imm = 1'b1; cw.aluop = ALU_FWD; end
      OP_MOV:   begin cw.we = 1'b1; cw.aluop = ALU_FWD; end
      OP_ADD:   begin cw.we = 1'b1; cw.aluop = ALU_ADD; end
      OP_SUB:   begin cw.we = 1'b1; cw.comp = 1'b1; cw.aluop = ALU_ADD; end
      OP_AND:   begin cw.we = 1'b1; cw.aluop = ALU_AND; end
      OP_OR:    begin cw.we = 1'b1; cw.aluop = ALU_OR; end
      OP_J:     cw.jump = 1'b1;
      OP_BEQ:   begin cw.branch = 1'b1; cw.comp = 1'b1; cw.aluop = ALU_ADD; end
      OP_LWD:   begin cw.read = 1'b1; cw.aluop = ALU_FWD; end
      OP_LWI:   begin cw.read = 1'b1; cw.imm = 1'b1; cw.aluop = ALU_FWD; end
      OP_SWD:   begin cw.write = 1'b1; cw.aluop = ALU_FWD; end
      OP_SWI:   begin cw.write = 1'b1; cw.imm = 1'b1; cw.aluop = ALU_FWD; end
`ifdef CTRL_OPCODE_EXT_EN
      OP_BNE:   begin cw.bne = 1'b1; cw.comp = 1'b1; cw.aluop = ALU_ADD; end
      OP_SLL:   begin cw.we = 1'b1; cw.aluop = ALU_SHIFT; cw.shift_mode = SH_SLL; end
      OP_SRL:   begin cw.we = 1'b1; cw.aluop = ALU_SHIFT; cw.shift_mode = SH_SRL; end
      OP_SRA:   begin cw.we = 1'b1; cw.aluop = ALU_SHIFT; cw.shift_mode = SH_SRA; end
      OP_ROR:   begin
        cw.we = 1'b1; cw.imm = 1'b1; cw.aluop = ALU_SHIFT; cw.shift_mode = SH_ROR;
      end
      OP_MULT:  begin cw.we = 1'b1; cw.aluop = ALU_MULT; end
`endif
      default:  legal = 1'b0;
    endcase
  end

  assign is_mem  = cw.read | cw.write;
  assign is_load = cw.read;

endmodule

`default_nettype wire

// File: rtl/ctrl_unit_seq.sv
// +-----------------------------------------------------------------------------
// | ctrl_unit_seq : registered FSM instruction control unit with memory
// | sequencing and traps. CTRL_OPCODE_EXT_EN enables extended opcodes. Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module ctrl_unit_seq
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int OPCODE_W    = 8,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTRUCTION,
  input  logic               INSTR_VALID,
  input  logic               BUSYWAIT,
  output logic               INSTR_READY,
  output logic               WRITEENABLE,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               COMPLEMENT_FLAG,
  output logic               IMMEDIATE_FLAG,
  output logic               BRANCH_FLAG,
  output logic               BNE_FLAG,
  output logic               JUMP_FLAG,
  output logic [1:0]         SHIFT_MODE,
  output logic               READ,
  output logic               WRITE,
  output logic               LOAD_WORD_FLAG,
  output logic               ILLEGAL_OP,
  output logic               MEM_TIMEOUT_ERR
);

  logic [OPCODE_W-1:0] opcode;
  logic                dec_legal, dec_is_mem, dec_is_load;
  ctrl_word_t          dec_cw;

  assign opcode = INSTRUCTION[INSTR_W-1 -: OPCODE_W];

  if (INSTR_W > OPCODE_W) begin : g_operand_sink
    logic unused_operand_bits;
    assign unused_operand_bits = ^INSTRUCTION[INSTR_W-OPCODE_W-1:0];
  end

  ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opcode  (opcode),
    .legal   (dec_legal),
    .is_mem  (dec_is_mem),
    .is_load (dec_is_load),
    .cw      (dec_cw)
  );

  state_t      state, state_nxt;
  ctrl_word_t  cw_q, cw_nxt;
  logic        is_mem_q, is_mem_nxt, is_load_q, is_load_nxt;
  logic [15:0] count, count_nxt;
  logic        accept;

  assign accept = (state == S_IDLE) && INSTR_VALID;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      count     <= '0;
      cw_q      <= '0;
      is_mem_q  <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      cw_q      <= cw_nxt;
      is_mem_q  <= is_mem_nxt;
      is_load_q <= is_load_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = '0;
    cw_nxt      = cw_q;
    is_mem_nxt  = is_mem_q;
    is_load_nxt = is_load_q;
    case (state)
      S_IDLE: if (INSTR_VALID) begin
        cw_nxt      = dec_cw;
        is_mem_nxt  = dec_is_mem;
        is_load_nxt = dec_is_load;
        state_nxt   = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: state_nxt = is_mem_q ? S_MEM : S_IDLE;
      S_MEM: begin
        count_nxt = count + 16'd1;
        // completion is checked first so it wins over a simultaneous timeout
        if (!BUSYWAIT)
          state_nxt = is_load_q ? S_WB : S_IDLE;
        else if (count_nxt >= 16'(MEM_TIMEOUT))
          state_nxt = S_TRAP;
      end
      S_WB:    state_nxt = S_IDLE;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs are registered, so they are decoded from the state being entered
  ctrl_word_t out_nxt;
  logic       ready_nxt, lwf_nxt, ill_nxt, tmo_nxt;

  always_comb begin
    out_nxt   = '0;
    ready_nxt = 1'b0;
    lwf_nxt   = 1'b0;
    case (state_nxt)
      S_IDLE: ready_nxt = 1'b1;
      S_EXEC: out_nxt = cw_nxt;
      S_MEM: begin
        out_nxt.read  = cw_nxt.read;
        out_nxt.write = cw_nxt.write;
        out_nxt.aluop = cw_nxt.aluop;
        out_nxt.imm   = cw_nxt.imm;
      end
      S_WB: begin
        out_nxt.we = 1'b1;
        lwf_nxt    = 1'b1;
      end
      default: ;
    endcase
`ifndef CTRL_OPCODE_EXT_EN
    out_nxt.bne        = 1'b0;
    out_nxt.shift_mode = SH_SLL;
`endif
    ill_nxt = ILLEGAL_OP | (accept & ~dec_legal);
    tmo_nxt = MEM_TIMEOUT_ERR | ((state == S_MEM) && (state_nxt == S_TRAP));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      INSTR_READY     <= 1'b1;
      WRITEENABLE     <= 1'b0;
      ALUOP           <= '0;
      COMPLEMENT_FLAG <= 1'b0;
      IMMEDIATE_FLAG  <= 1'b0;
      BRANCH_FLAG     <= 1'b0;
      BNE_FLAG        <= 1'b0;
      JUMP_FLAG       <= 1'b0;
      SHIFT_MODE      <= 2'b00;
      READ            <= 1'b0;
      WRITE           <= 1'b0;
      LOAD_WORD_FLAG  <= 1'b0;
      ILLEGAL_OP      <= 1'b0;
      MEM_TIMEOUT_ERR <= 1'b0;
    end else begin
      INSTR_READY     <= ready_nxt;
      WRITEENABLE     <= out_nxt.we;
      ALUOP           <= ALUOP_W'(out_nxt.aluop);
      COMPLEMENT_FLAG <= out_nxt.comp;
      IMMEDIATE_FLAG  <= out_nxt.imm;
      BRANCH_FLAG     <= out_nxt.branch;
      BNE_FLAG        <= out_nxt.bne;
      JUMP_FLAG       <= out_nxt.jump;
      SHIFT_MODE      <= out_nxt.shift_mode;
      READ            <= out_nxt.read;
      WRITE           <= out_nxt.write;
      LOAD_WORD_FLAG  <= lwf_nxt;
      ILLEGAL_OP      <= ill_nxt;
      MEM_TIMEOUT_ERR <= tmo_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_unit_seq.sv
// +-----------------------------------------------------------------------------
// | tb_ctrl_unit_seq : directed self-checking bench for ctrl_unit_seq
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ctrl_unit_seq;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 8;
  localparam int ALUOP_W  = 3;
  localparam int TMO      = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_VALID = 1'b0;
  logic        BUSYWAIT = 1'b0;
  logic        INSTR_READY, WRITEENABLE, COMPLEMENT_FLAG, IMMEDIATE_FLAG;
  logic        BRANCH_FLAG, BNE_FLAG, JUMP_FLAG, READ, WRITE;
  logic        LOAD_WORD_FLAG, ILLEGAL_OP, MEM_TIMEOUT_ERR;
  logic [2:0]  ALUOP;
  logic [1:0]  SHIFT_MODE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ctrl_unit_seq #(
    .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .BUSYWAIT(BUSYWAIT), .INSTR_READY(INSTR_READY), .WRITEENABLE(WRITEENABLE),
    .ALUOP(ALUOP), .COMPLEMENT_FLAG(COMPLEMENT_FLAG), .IMMEDIATE_FLAG(IMMEDIATE_FLAG),
    .BRANCH_FLAG(BRANCH_FLAG), .BNE_FLAG(BNE_FLAG), .JUMP_FLAG(JUMP_FLAG),
    .SHIFT_MODE(SHIFT_MODE), .READ(READ), .WRITE(WRITE),
    .LOAD_WORD_FLAG(LOAD_WORD_FLAG), .ILLEGAL_OP(ILLEGAL_OP),
    .MEM_TIMEOUT_ERR(MEM_TIMEOUT_ERR)
  );

  // {ready, we, aluop[2:0], comp, imm, br, bne, jmp, shift[1:0], rd, wr, lwf, ill, tmo}
  logic [16:0] outs;
  assign outs = {INSTR_READY, WRITEENABLE, ALUOP, COMPLEMENT_FLAG, IMMEDIATE_FLAG,
                 BRANCH_FLAG, BNE_FLAG, JUMP_FLAG, SHIFT_MODE, READ, WRITE,
                 LOAD_WORD_FLAG, ILLEGAL_OP, MEM_TIMEOUT_ERR};

  function automatic logic [16:0] ov(input int rdy, we, alu, comp, imm, br, bne, jmp,
                                     sh, rd, wr, lw, ill, tmo);
    return {1'(rdy), 1'(we), 3'(alu), 1'(comp), 1'(imm), 1'(br), 1'(bne), 1'(jmp),
            2'(sh), 1'(rd), 1'(wr), 1'(lw), 1'(ill), 1'(tmo)};
  endfunction

  localparam logic [16:0] IDLE_V = 17'h10000;
  localparam logic [16:0] TRAP_ILL = 17'h00002;
  localparam logic [16:0] TRAP_TMO = 17'h00001;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [7:0] op);
    INSTRUCTION = {op, 24'($urandom)};
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL reset_state: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_alu_ops();
    logic [7:0]  op_tab  [8];
    logic [16:0] exp_tab [8];
    op_tab  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    exp_tab = '{ov(0,1,0,0,1,0,0,0,0,0,0,0,0,0),   // loadi
                ov(0,1,0,0,0,0,0,0,0,0,0,0,0,0),   // mov
                ov(0,1,1,0,0,0,0,0,0,0,0,0,0,0),   // add
                ov(0,1,1,1,0,0,0,0,0,0,0,0,0,0),   // sub
                ov(0,1,2,0,0,0,0,0,0,0,0,0,0,0),   // and
                ov(0,1,3,0,0,0,0,0,0,0,0,0,0,0),   // or
                ov(0,0,0,0,0,0,0,1,0,0,0,0,0,0),   // j
                ov(0,0,1,1,0,1,0,0,0,0,0,0,0,0)};  // beq
    for (int i = 0; i < 8; i++) begin
      issue(op_tab[i]);
      checks++;
      if (outs !== exp_tab[i]) begin
        errors++; $display("FAIL exec_op%02h: got %h expected %h", op_tab[i], outs, exp_tab[i]);
      end
      tick();
      checks++;
      if (outs !== IDLE_V) begin
        errors++; $display("FAIL idle_after_op%02h: got %h expected %h", op_tab[i], outs, IDLE_V);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e_add, e_or;
    e_add = ov(0,1,1,0,0,0,0,0,0,0,0,0,0,0);
    e_or  = ov(0,1,3,0,0,0,0,0,0,0,0,0,0,0);
    INSTRUCTION = 32'h02A5_5A01;
    INSTR_VALID = 1'b1;
    tick();
    checks++;
    if (outs !== e_add) begin
      errors++; $display("FAIL b2b_first: got %h expected %h", outs, e_add);
    end
    INSTRUCTION = 32'h0512_3456;
    tick();
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL b2b_gap: got %h expected %h", outs, IDLE_V);
    end
    tick();
    INSTR_VALID = 1'b0;
    checks++;
    if (outs !== e_or) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", outs, e_or);
    end
    tick();
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL b2b_idle: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_load();
    logic [16:0] e_rd, e_wb;
    e_rd = ov(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    e_wb = ov(0,1,0,0,0,0,0,0,0,0,0,1,0,0);
    BUSYWAIT = 1'b1;
    issue(8'h08);
    // READ high for EXEC + three S_MEM cycles; BUSYWAIT drops in the third
    for (int c = 0; c < 4; c++) begin
      if (c == 3) BUSYWAIT = 1'b0;
      checks++;
      if (outs !== e_rd) begin
        errors++; $display("FAIL lwd_read_c%0d: got %h expected %h", c, outs, e_rd);
      end
      if (c < 3) tick();
    end
    tick();
    checks++;
    if (outs !== e_wb) begin
      errors++; $display("FAIL lwd_writeback: got %h expected %h", outs, e_wb);
    end
    tick();
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL lwd_idle: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_completion_wins();
    logic [16:0] e_rd, e_wb;
    e_rd = ov(0,0,0,0,1,0,0,0,0,1,0,0,0,0);
    e_wb = ov(0,1,0,0,0,0,0,0,0,0,0,1,0,0);
    BUSYWAIT = 1'b1;
    issue(8'h09);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) BUSYWAIT = 1'b0;
      checks++;
      if (outs !== e_rd) begin
        errors++; $display("FAIL lwi_read_c%0d: got %h expected %h", c, outs, e_rd);
      end
      if (c < 4) tick();
    end
    tick();
    checks++;
    if (outs !== e_wb) begin
      errors++; $display("FAIL lwi_edge_completion: got %h expected %h", outs, e_wb);
    end
    tick();
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL lwi_idle: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_timeout();
    logic [16:0] e_wr;
    e_wr = ov(0,0,0,0,1,0,0,0,0,0,1,0,0,0);
    BUSYWAIT = 1'b1;
    issue(8'h0B);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (outs !== e_wr) begin
        errors++; $display("FAIL swi_write_c%0d: got %h expected %h", c, outs, e_wr);
      end
      tick();
    end
    checks++;
    if (outs !== TRAP_TMO) begin
      errors++; $display("FAIL swi_timeout_trap: got %h expected %h", outs, TRAP_TMO);
    end
    BUSYWAIT = 1'b0;
    issue(8'h02);
    tick();
    checks++;
    if (outs !== TRAP_TMO) begin
      errors++; $display("FAIL timeout_sticky: got %h expected %h", outs, TRAP_TMO);
    end
    do_reset();
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL timeout_reset: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_illegal();
    issue(8'hFF);
    checks++;
    if (outs !== TRAP_ILL) begin
      errors++; $display("FAIL illegal_trap: got %h expected %h", outs, TRAP_ILL);
    end
    issue(8'h01);
    tick();
    checks++;
    if (outs !== TRAP_ILL) begin
      errors++; $display("FAIL illegal_ignores_valid: got %h expected %h", outs, TRAP_ILL);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL async_reset_trap: got %h expected %h", outs, IDLE_V);
    end
    RESET = 1'b0;
    tick();
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL idle_after_async_reset: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_ext_opcodes();
`ifdef CTRL_OPCODE_EXT_EN
    logic [16:0] e_bne, e_sra;
    e_bne = ov(0,0,1,1,0,0,1,0,0,0,0,0,0,0);
    e_sra = ov(0,1,5,0,0,0,0,0,2,0,0,0,0,0);
    issue(8'h0C);
    checks++;
    if (outs !== e_bne) begin
      errors++; $display("FAIL ext_bne: got %h expected %h", outs, e_bne);
    end
    tick();
    issue(8'h0F);
    checks++;
    if (outs !== e_sra) begin
      errors++; $display("FAIL ext_sra: got %h expected %h", outs, e_sra);
    end
    tick();
`else
    issue(8'h0C);
    checks++;
    if (outs !== TRAP_ILL) begin
      errors++; $display("FAIL noext_0c_illegal: got %h expected %h", outs, TRAP_ILL);
    end
    do_reset();
    issue(8'h0F);
    checks++;
    if (outs !== TRAP_ILL) begin
      errors++; $display("FAIL noext_0f_illegal: got %h expected %h", outs, TRAP_ILL);
    end
    do_reset();
`endif
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL ext_idle: got %h expected %h", outs, IDLE_V);
    end
  endtask

  task automatic test_reset_in_mem();
    logic [16:0] e_rd;
    e_rd = ov(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    BUSYWAIT = 1'b1;
    issue(8'h08);
    tick();
    checks++;
    if (outs !== e_rd) begin
      errors++; $display("FAIL rst_mem_read: got %h expected %h", outs, e_rd);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (outs !== IDLE_V) begin
      errors++; $display("FAIL rst_mem_async: got %h expected %h", outs, IDLE_V);
    end
    RESET = 1'b0;
    BUSYWAIT = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (outs !== IDLE_V) begin
        errors++; $display("FAIL rst_mem_no_wb_c%0d: got %h expected %h", c, outs, IDLE_V);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_load();
    test_completion_wins();
    test_timeout();
    test_illegal();
    test_ext_opcodes();
    test_reset_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
